// File: rtl/bipolar_step_decoder.sv
// Bipolar stepper coil-pin decoder: synchronizes and filters the four H-bridge lines,
// then tracks half-step phase, signed position, direction, step count and step period.
module bipolar_step_decoder #(
    parameter int unsigned FILTER_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_clear,
    input  logic [31:0] i_preset_position,
    input  logic        i_hbridge0_l,
    input  logic        i_hbridge0_r,
    input  logic        i_hbridge1_l,
    input  logic        i_hbridge1_r,
    output logic [31:0] o_current_position,
    output logic [7:0]  o_step_pos,
    output logic [31:0] o_step_count,
    output logic        o_direction,
    output logic        o_step_strobe,
    output logic [31:0] o_step_period,
    output logic        o_error,
    output logic        o_coils_off
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_LOCK  = 2'd1;
    localparam logic [1:0]  ST_TRACK = 2'd2;
    localparam logic [16:0] FILT_LIM = 17'(FILTER_CYCLES);

    // Returns {legal, phase index}; 0000 and shoot-through patterns report not legal.
    function automatic logic [3:0] phase_of(input logic [3:0] p);
        case (p)
            4'b1000: phase_of = 4'b1_000;
            4'b1010: phase_of = 4'b1_001;
            4'b0010: phase_of = 4'b1_010;
            4'b0110: phase_of = 4'b1_011;
            4'b0100: phase_of = 4'b1_100;
            4'b0101: phase_of = 4'b1_101;
            4'b0001: phase_of = 4'b1_110;
            4'b1001: phase_of = 4'b1_111;
            default: phase_of = 4'b0_000;
        endcase
    endfunction

    logic [3:0]  pins;
    logic [3:0]  sync1_q, sync2_q, prev_q;
    logic [15:0] filt_cnt_q, filt_cnt_d;
    logic        filt_done_q, filt_done_d;
    logic [16:0] run_len;
    logic        changed, accept;
    logic [3:0]  phase_info;
    logic [2:0]  delta;
    logic [31:0] per_inc;

    logic [1:0]  state_q, state_d;
    logic [31:0] pos_q, pos_d;
    logic [31:0] count_q, count_d;
    logic [31:0] period_q, period_d;
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [2:0]  step_pos_q, step_pos_d;
    logic        dir_q, dir_d;
    logic        strobe_q, strobe_d;
    logic        err_q, err_d;
    logic        coils_off_q, coils_off_d;

    assign pins       = {i_hbridge0_l, i_hbridge0_r, i_hbridge1_l, i_hbridge1_r};
    assign changed    = (sync2_q != prev_q);
    assign run_len    = changed ? 17'd1 : ({1'b0, filt_cnt_q} + 17'd1);
    // A settled pattern is evaluated exactly once; the done flag re-arms on the next change.
    assign accept     = (run_len >= FILT_LIM) && (changed || !filt_done_q);
    assign phase_info = phase_of(sync2_q);
    assign delta      = phase_info[2:0] - step_pos_q;
    assign per_inc    = (per_cnt_q == 32'hFFFF_FFFF) ? per_cnt_q : per_cnt_q + 32'd1;

    always_comb begin
        filt_cnt_d  = (run_len >= FILT_LIM) ? FILT_LIM[15:0] : run_len[15:0];
        filt_done_d = accept | (filt_done_q & ~changed);
    end

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        count_d     = count_q;
        period_d    = period_q;
        per_cnt_d   = per_cnt_q;
        step_pos_d  = step_pos_q;
        dir_d       = dir_q;
        strobe_d    = 1'b0;
        err_d       = err_q;
        coils_off_d = coils_off_q;

        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_LOCK;
                ST_LOCK: begin
                    if (accept) begin
                        coils_off_d = (sync2_q == 4'b0000);
                        if (phase_info[3]) begin
                            step_pos_d = phase_info[2:0];
                            per_cnt_d  = 32'd0;
                            state_d    = ST_TRACK;
                        end
                    end
                end
                ST_TRACK: begin
                    per_cnt_d = per_inc;
                    if (accept) begin
                        coils_off_d = (sync2_q == 4'b0000);
                        if (!phase_info[3]) begin
                            if (sync2_q != 4'b0000) err_d = 1'b1;
                            state_d = ST_LOCK;
                        end else if (delta == 3'd1 || delta == 3'd7) begin
                            pos_d      = (delta == 3'd1) ? pos_q + 32'd1 : pos_q - 32'd1;
                            dir_d      = (delta == 3'd1);
                            count_d    = count_q + 32'd1;
                            strobe_d   = 1'b1;
                            period_d   = per_inc;
                            per_cnt_d  = 32'd0;
                            step_pos_d = phase_info[2:0];
                        end else if (delta != 3'd0) begin
                            err_d      = 1'b1;
                            step_pos_d = phase_info[2:0];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Clear overrides any same-cycle step on position, count and period.
        if (i_clear) begin
            pos_d     = i_preset_position;
            count_d   = 32'd0;
            err_d     = 1'b0;
            period_d  = 32'd0;
            per_cnt_d = 32'd0;
            strobe_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 4'b0000;
            sync2_q     <= 4'b0000;
            prev_q      <= 4'b0000;
            filt_cnt_q  <= 16'd0;
            filt_done_q <= 1'b0;
            state_q     <= ST_IDLE;
            pos_q       <= 32'd0;
            count_q     <= 32'd0;
            period_q    <= 32'd0;
            per_cnt_q   <= 32'd0;
            step_pos_q  <= 3'd0;
            dir_q       <= 1'b0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            coils_off_q <= 1'b1;
        end else begin
            sync1_q     <= pins;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            filt_cnt_q  <= filt_cnt_d;
            filt_done_q <= filt_done_d;
            state_q     <= state_d;
            pos_q       <= pos_d;
            count_q     <= count_d;
            period_q    <= period_d;
            per_cnt_q   <= per_cnt_d;
            step_pos_q  <= step_pos_d;
            dir_q       <= dir_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
            coils_off_q <= coils_off_d;
        end
    end

    assign o_current_position = pos_q;
    assign o_step_pos         = {5'd0, step_pos_q};
    assign o_step_count       = count_q;
    assign o_direction        = dir_q;
    assign o_step_strobe      = strobe_q;
    assign o_step_period      = period_q;
    assign o_error            = err_q;
    assign o_coils_off        = coils_off_q;

endmodule

// File: tb/tb_bipolar_step_decoder.sv
// Scoreboard bench for bipolar_step_decoder with a 4-cycle filter.
module tb_bipolar_step_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable, i_clear;
    logic [31:0] i_preset_position;
    logic        l0, r0, l1, r1;
    logic [31:0] o_current_position, o_step_count, o_step_period;
    logic [7:0]  o_step_pos;
    logic        o_direction, o_step_strobe, o_error, o_coils_off;

    bipolar_step_decoder #(.FILTER_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_clear(i_clear),
        .i_preset_position(i_preset_position),
        .i_hbridge0_l(l0), .i_hbridge0_r(r0), .i_hbridge1_l(l1), .i_hbridge1_r(r1),
        .o_current_position(o_current_position), .o_step_pos(o_step_pos),
        .o_step_count(o_step_count), .o_direction(o_direction),
        .o_step_strobe(o_step_strobe), .o_step_period(o_step_period),
        .o_error(o_error), .o_coils_off(o_coils_off)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pos;
        logic [31:0] cnt;
        logic        dir;
        logic [7:0]  sp;
        logic [31:0] per;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pos, m_cnt;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && o_step_strobe === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got pos=%h cnt=%0d required no strobe", o_current_position, o_step_count);
            end else begin
                e = sb_q.pop_front();
                if ({o_current_position, o_step_count, o_direction, o_step_pos, o_step_period} !== e) begin
                    errors++;
                    $display("FAIL strobe_values got pos=%h cnt=%0d dir=%0d sp=%0d per=%0d required pos=%h cnt=%0d dir=%0d sp=%0d per=%0d",
                             o_current_position, o_step_count, o_direction, o_step_pos, o_step_period,
                             e.pos, e.cnt, e.dir, e.sp, e.per);
                end
            end
        end
    end

    function automatic logic [3:0] pat(input int ph);
        case (ph)
            0: pat = 4'b1000; 1: pat = 4'b1010; 2: pat = 4'b0010; 3: pat = 4'b0110;
            4: pat = 4'b0100; 5: pat = 4'b0101; 6: pat = 4'b0001; default: pat = 4'b1001;
        endcase
    endfunction

    task automatic drive(input logic [3:0] p);
        {l0, r0, l1, r1} = p;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_to(input int ph, input logic up, input logic [31:0] per);
        m_pos = up ? m_pos + 32'd1 : m_pos - 32'd1;
        m_cnt = m_cnt + 32'd1;
        sb_q.push_back({m_pos, m_cnt, up, 8'(ph), per});
        drive(pat(ph));
        wait_cyc(20);
    endtask

    task automatic pulse_clear(input logic [31:0] preset);
        i_preset_position = preset;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    task automatic test_reset;
        wait_cyc(3);
        checks++;
        if ({o_current_position, o_step_count, o_step_period} !== 96'd0) begin
            errors++;
            $display("FAIL reset_words got pos=%h cnt=%h per=%h required 0", o_current_position, o_step_count, o_step_period);
        end
        checks++;
        if ({o_step_pos, o_direction, o_step_strobe, o_error, o_coils_off} !== 12'b0000_0000_0001) begin
            errors++;
            $display("FAIL reset_flags got sp=%0d dir=%b stb=%b err=%b off=%b required 0,0,0,0,1",
                     o_step_pos, o_direction, o_step_strobe, o_error, o_coils_off);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock_and_step;
        int lat;
        i_enable = 1'b1;
        wait_cyc(5);
        drive(pat(0));
        wait_cyc(20);
        checks++;
        if (o_step_pos !== 8'd0 || o_coils_off !== 1'b0 || o_step_count !== 32'd0) begin
            errors++;
            $display("FAIL lock_phase0 got sp=%0d off=%b cnt=%0d required 0,0,0", o_step_pos, o_coils_off, o_step_count);
        end
        m_pos = 32'd0;
        m_cnt = 32'd0;
        m_pos = m_pos + 32'd1;
        m_cnt = m_cnt + 32'd1;
        sb_q.push_back({m_pos, m_cnt, 1'b1, 8'd1, 32'd20});
        drive(pat(1));
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_step_strobe === 1'b1 && lat < 0) lat = k;
        end
        checks++;
        if (lat != 6) begin
            errors++;
            $display("FAIL strobe_latency got %0d required 6", lat);
        end
        checks++;
        if (o_current_position !== 32'd1 || o_step_count !== 32'd1 || o_direction !== 1'b1 || o_step_pos !== 8'd1) begin
            errors++;
            $display("FAIL first_step got pos=%h cnt=%0d dir=%b sp=%0d required 1,1,1,1",
                     o_current_position, o_step_count, o_direction, o_step_pos);
        end
    endtask

    task automatic test_descending;
        drive(4'b0000);
        wait_cyc(20);
        checks++;
        if (o_coils_off !== 1'b1) begin
            errors++;
            $display("FAIL coils_off_track got %b required 1", o_coils_off);
        end
        pulse_clear(32'd0);
        m_pos = 32'd0;
        m_cnt = 32'd0;
        drive(pat(0));
        wait_cyc(20);
        checks++;
        if (o_step_pos !== 8'd0 || o_current_position !== 32'd0 || o_step_count !== 32'd0) begin
            errors++;
            $display("FAIL relock_phase0 got sp=%0d pos=%h cnt=%0d required 0,0,0", o_step_pos, o_current_position, o_step_count);
        end
        for (int ph = 7; ph >= 1; ph--) step_to(ph, 1'b0, 32'd20);
        checks++;
        if (o_current_position !== 32'hFFFF_FFF9 || o_step_count !== 32'd7 || o_direction !== 1'b0 || o_step_period !== 32'd20) begin
            errors++;
            $display("FAIL descending got pos=%h cnt=%0d dir=%b per=%0d required FFFFFFF9,7,0,20",
                     o_current_position, o_step_count, o_direction, o_step_period);
        end
    endtask

    task automatic test_glitch;
        repeat (8) begin
            drive(4'b1000);
            wait_cyc(2);
            drive(4'b1010);
            wait_cyc(1);
        end
        wait_cyc(20);
        checks++;
        if (o_current_position !== m_pos || o_step_count !== m_cnt || o_error !== 1'b0 || o_step_pos !== 8'd1) begin
            errors++;
            $display("FAIL glitch_reject got pos=%h cnt=%0d err=%b sp=%0d required %h,%0d,0,1",
                     o_current_position, o_step_count, o_error, o_step_pos, m_pos, m_cnt);
        end
    endtask

    task automatic test_error_jump;
        drive(pat(4));
        wait_cyc(20);
        checks++;
        if (o_error !== 1'b1 || o_step_pos !== 8'd4 || o_current_position !== m_pos || o_step_count !== m_cnt) begin
            errors++;
            $display("FAIL skip_error got err=%b sp=%0d pos=%h cnt=%0d required 1,4,%h,%0d",
                     o_error, o_step_pos, o_current_position, o_step_count, m_pos, m_cnt);
        end
        drive(4'b1100);
        wait_cyc(20);
        checks++;
        if (o_error !== 1'b1 || o_coils_off !== 1'b0) begin
            errors++;
            $display("FAIL shoot_through got err=%b off=%b required 1,0", o_error, o_coils_off);
        end
        drive(pat(5));
        wait_cyc(20);
        checks++;
        if (o_step_pos !== 8'd5 || o_step_count !== m_cnt || o_current_position !== m_pos) begin
            errors++;
            $display("FAIL relock_no_count got sp=%0d cnt=%0d pos=%h required 5,%0d,%h",
                     o_step_pos, o_step_count, o_current_position, m_cnt, m_pos);
        end
        step_to(6, 1'b1, 32'd20);
        checks++;
        if (o_step_count !== 32'd8 || o_current_position !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL track_after_relock got cnt=%0d pos=%h required 8,FFFFFFFA", o_step_count, o_current_position);
        end
    endtask

    task automatic test_clear_wrap;
        pulse_clear(32'h7FFF_FFFF);
        checks++;
        if (o_current_position !== 32'h7FFF_FFFF || o_step_count !== 32'd0 || o_error !== 1'b0 || o_step_period !== 32'd0) begin
            errors++;
            $display("FAIL clear got pos=%h cnt=%0d err=%b per=%0d required 7FFFFFFF,0,0,0",
                     o_current_position, o_step_count, o_error, o_step_period);
        end
        m_pos = 32'h7FFF_FFFF;
        m_cnt = 32'd0;
        step_to(7, 1'b1, 32'd6);
        checks++;
        if (o_current_position !== 32'h8000_0000 || o_step_count !== 32'd1) begin
            errors++;
            $display("FAIL wrap_pos got pos=%h cnt=%0d required 80000000,1", o_current_position, o_step_count);
        end
        drive(pat(0));
        wait_cyc(5);
        i_preset_position = 32'h1234_5678;
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        checks++;
        if (o_step_strobe !== 1'b0 || o_current_position !== 32'h1234_5678 || o_step_count !== 32'd0 ||
            o_step_period !== 32'd0 || o_step_pos !== 8'd0 || o_direction !== 1'b1) begin
            errors++;
            $display("FAIL clear_with_step got stb=%b pos=%h cnt=%0d per=%0d sp=%0d dir=%b required 0,12345678,0,0,0,1",
                     o_step_strobe, o_current_position, o_step_count, o_step_period, o_step_pos, o_direction);
        end
        m_pos = 32'h1234_5678;
        m_cnt = 32'd0;
        wait_cyc(20);
    endtask

    task automatic test_coils_off_reset;
        drive(4'b0000);
        wait_cyc(20);
        drive(pat(1));
        wait_cyc(20);
        checks++;
        if (o_step_pos !== 8'd1 || o_coils_off !== 1'b0 || o_step_count !== 32'd0 || o_current_position !== m_pos) begin
            errors++;
            $display("FAIL lock_after_off got sp=%0d off=%b cnt=%0d pos=%h required 1,0,0,%h",
                     o_step_pos, o_coils_off, o_step_count, o_current_position, m_pos);
        end
        drive(pat(2));
        wait_cyc(3);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_current_position, o_step_count, o_step_period, o_step_pos, o_direction, o_step_strobe, o_error, o_coils_off}
            !== {96'd0, 12'b0000_0000_0001}) begin
            errors++;
            $display("FAIL async_reset got pos=%h cnt=%0d per=%0d sp=%0d dir=%b stb=%b err=%b off=%b required zeros with off=1",
                     o_current_position, o_step_count, o_step_period, o_step_pos, o_direction, o_step_strobe, o_error, o_coils_off);
        end
        @(negedge clk);
        rst = 1'b0;
        m_pos = 32'd0;
        m_cnt = 32'd0;
        wait_cyc(20);
        checks++;
        if (o_step_pos !== 8'd2 || o_step_count !== 32'd0) begin
            errors++;
            $display("FAIL resume_lock got sp=%0d cnt=%0d required 2,0", o_step_pos, o_step_count);
        end
        step_to(3, 1'b1, 32'd20);
        checks++;
        if (o_current_position !== 32'd1 || o_step_count !== 32'd1) begin
            errors++;
            $display("FAIL resume_step got pos=%h cnt=%0d required 1,1", o_current_position, o_step_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0;
        i_clear = 1'b0;
        i_preset_position = 32'd0;
        {l0, r0, l1, r1} = 4'b0000;
        m_pos = 32'd0;
        m_cnt = 32'd0;
        test_reset();
        test_lock_and_step();
        test_descending();
        test_glitch();
        test_error_jump();
        test_clear_wrap();
        test_coils_off_reset();
        wait_cyc(2);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes got %0d pending required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
